hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Hazard and run-control sequencer for the five-stage pipeline. It sits in the ID stage. It watches the IF/ID instruction fields and the ID/EX and EX/MEM destination and control bits, and from them drives the PC hold, the IF/ID hold and flush, the ID/EX bubble, and the ID-stage branch-compare forwarding selects (Fw1/Fw2). It also provides halt and single-step run control for board debugging, plus saturating stall and flush counters.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  5 each  IF/ID instr[25:21] and [20:16].
- id_uses_rs, id_uses_rt  in  1 each  the ID instruction reads rs / rt.
- id_is_branch  in  1  beq or bne in ID.
- id_is_jump  in  1  j in ID.
- br_taken  in  1  branch condition, already resolved (IfEqual XOR bne).
- ex_memread, ex_regwrite  in  1 each  ID/EX MemRead and RegWrite.
- ex_dst  in  5  ID/EX destination register, after the RegDst mux.
- mem_memread, mem_regwrite  in  1 each  EX/MEM MemRead and RegWrite.
- mem_dst  in  5  EX/MEM RegisterDst.
- halt_req  in  1  level request to halt.
- step_req  in  1  single-cycle pulse that advances one cycle while halted.
- clr_cnt  in  1  synchronous clear of both counters.
- pc_hold, if_id_hold  out  1 each  freeze PC / IF/ID.
- id_ex_flush  out  1  load a bubble (all control bits zero) into ID/EX.
- if_id_flush  out  1  squash the instruction currently being fetched.
- fw1, fw2  out  1 each  select the EX/MEM ALU result for the ID compare operands.
- halted  out  1  the FSM is in HALT.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

## Operation
Match terms (all combinational):
- match(d, r) = d != 0 && d == r, restricted to operands the ID instruction actually uses.
- ex_hit = match(ex_dst, rs or rt).
- mem_hit = match(mem_dst, rs or rt).

Required stall count N for the instruction in ID:
- Non-branch instruction: N = 1 if ex_memread && ex_hit (load-use), otherwise N = 0.
- Branch instruction, evaluated in this order:
  - N = 2 if ex_memread && ex_hit.
  - N = 1 if ex_regwrite && ex_hit.
  - N = 1 if mem_memread && mem_hit.
  - N = 0 otherwise.
- A jump has N = 0.

Forwarding:
- fw1 = mem_regwrite && !mem_memread && mem_dst != 0 && mem_dst == id_rs.
- fw2 is the same expression with id_rt.

FSM states are RUN, STALL2, HALT and STEP.
- RUN:
  - If N ≥ 1: assert the stall outputs (pc_hold = if_id_hold = id_ex_flush = 1, if_id_flush = 0). If N == 2, go to STALL2; otherwise stay in RUN.
  - If N == 0: the pipeline advances. if_id_flush = id_is_jump || (id_is_branch && br_taken). If halt_req, go to HALT; otherwise stay in RUN.
- STALL2: assert the stall outputs unconditionally, then go to RUN. halt_req is ignored here and is re-sampled in RUN.
- HALT: pc_hold = if_id_hold = id_ex_flush = 1, so bubbles drain the later stages. halted = 1.
  - step_req goes to STEP.
  - Otherwise, if !halt_req, go to RUN.
  - step_req has priority over the release of halt_req.
- STEP: behaves exactly like RUN for one cycle, including stalls and flushes. The next state is HALT. The exception is N == 2, which goes to STALL2; from there the FSM returns to RUN, and that RUN cycle goes back to HALT if halt_req is still high.

Counters:
- stall_cnt increments on every cycle the stall outputs are asserted in RUN, STALL2 or STEP. HALT cycles are excluded.
- flush_cnt increments on every cycle that if_id_flush = 1.
- Both counters saturate at all-ones.
- clr_cnt zeroes both counters and overrides any increment in the same cycle.

## Timing
While reset is low:
- state = RUN and both counters = 0.
- pc_hold = if_id_hold = id_ex_flush = 1.
- if_id_flush = fw1 = fw2 = halted = 0.

Reset behaviour:
- Reset may be asserted mid-stall or mid-halt; the block returns to RUN with no residual stall.
- The stall gating is released on the first clock edge after reset deasserts.

Output timing:
- All hold, flush and forward outputs are combinational from the current state and inputs. There is zero latency from a hazard appearing to the stall being asserted in the same cycle.
- State and counters update on the rising edge of clock only.
- Stalls take priority over branch and jump flushes; a branch that is being stalled is re-evaluated after the stall completes.
- halt_req takes effect on the clock edge following a RUN cycle with N = 0. That cycle's instruction still advances.

## Test plan
- Load-use: ex_memread = 1, ex_dst = 5, ID uses rs = 5 as a non-branch → exactly one cycle with pc_hold/if_id_hold/id_ex_flush = 1, state stays RUN, and stall_cnt goes from 0 to 1.
- Branch after load: ID beq with rs = 8, ex_memread = 1, ex_dst = 8 → two consecutive stall cycles (RUN → STALL2 → RUN) and stall_cnt = 2. On the third cycle mem_regwrite = 1 with mem_dst = 8 gives fw1 = 1 and no stall.
- Taken branch and jump: beq with br_taken = 1 and no hazard → if_id_flush = 1 for one cycle and flush_cnt = 1. A subsequent j gives flush_cnt = 2. A not-taken bne gives no flush.
- Register zero: ex_memread = 1, ex_dst = 0, rs = 0 → no stall, and fw1 = 0 even with mem_dst = 0 and mem_regwrite = 1.
- Halt and step: raise halt_req → halted = 1 on the next cycle and the holds stay asserted. A one-cycle step_req gives exactly one cycle with halted = 0, then halted = 1 again. Dropping halt_req returns the FSM to RUN. stall_cnt is unchanged across HALT cycles.
- Reset and counters:
  - Pull reset low during STALL2 → the FSM is in RUN with the counters at 0 immediately.
  - Force stall_cnt to 0xFFFF → it holds at 0xFFFF across further stalls.
  - clr_cnt asserted together with a stall → stall_cnt = 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ID-stage hazard and run-control sequencer: load-use and branch-compare stalls,
// branch/jump squash, compare-operand forwarding, halt/single-step and event counters.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             id_is_jump,
  input  logic             br_taken,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic [4:0]       ex_dst,
  input  logic             mem_memread,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_dst,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             clr_cnt,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             id_ex_flush,
  output logic             if_id_flush,
  output logic             fw1,
  output logic             fw2,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, STALL2, HALT, STEP} state_e;

  state_e            state_q, state_d;
  logic              live_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              ex_hit, mem_hit;
  logic [1:0]        n_stall;
  logic              stall, squash, in_halt;

  assign ex_hit  = (ex_dst != 5'd0) &&
                   ((id_uses_rs && ex_dst == id_rs) || (id_uses_rt && ex_dst == id_rt));
  assign mem_hit = (mem_dst != 5'd0) &&
                   ((id_uses_rs && mem_dst == id_rs) || (id_uses_rt && mem_dst == id_rt));

  // Branches compare in ID, so they also wait on ALU results still in EX and loads in MEM.
  always_comb begin
    n_stall = 2'd0;
    if (id_is_jump)                        n_stall = 2'd0;
    else if (id_is_branch) begin
      if (ex_memread && ex_hit)            n_stall = 2'd2;
      else if (ex_regwrite && ex_hit)      n_stall = 2'd1;
      else if (mem_memread && mem_hit)     n_stall = 2'd1;
    end else if (ex_memread && ex_hit)     n_stall = 2'd1;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    squash  = 1'b0;
    in_halt = 1'b0;
    unique case (state_q)
      RUN, STEP: begin
        if (n_stall != 2'd0) begin
          stall = 1'b1;
          if (n_stall == 2'd2)      state_d = STALL2;
          else if (state_q == STEP) state_d = HALT;
          else                      state_d = RUN;
        end else begin
          squash  = id_is_jump || (id_is_branch && br_taken);
          state_d = (state_q == STEP || halt_req) ? HALT : RUN;
        end
      end
      STALL2: begin
        stall   = 1'b1;
        state_d = RUN;
      end
      HALT: begin
        in_halt = 1'b1;
        if (step_req)      state_d = STEP;
        else if (!halt_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    // First cycle out of reset keeps the pipeline frozen and does nothing else.
    if (!live_q) begin
      stall   = 1'b0;
      squash  = 1'b0;
      state_d = state_q;
    end
  end

  assign pc_hold     = !live_q || stall || in_halt;
  assign if_id_hold  = pc_hold;
  assign id_ex_flush = pc_hold;
  assign if_id_flush = squash;
  assign halted      = in_halt;
  assign fw1 = live_q && mem_regwrite && !mem_memread && (mem_dst != 5'd0) && (mem_dst == id_rs);
  assign fw2 = live_q && mem_regwrite && !mem_memread && (mem_dst != 5'd0) && (mem_dst == id_rt);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall  && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
      if (squash && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      live_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      live_q      <= 1'b1;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-computed holds, flushes, forwards, run control and counters.
module tb_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_dst, mem_dst;
  logic        id_uses_rs, id_uses_rt, id_is_branch, id_is_jump, br_taken;
  logic        ex_memread, ex_regwrite, mem_memread, mem_regwrite;
  logic        halt_req, step_req, clr_cnt;
  logic        pc_hold, if_id_hold, id_ex_flush, if_id_flush, fw1, fw2, halted;
  logic [15:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  hazard_ctrl #(.CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_is_jump(id_is_jump), .br_taken(br_taken),
    .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_dst(ex_dst),
    .mem_memread(mem_memread), .mem_regwrite(mem_regwrite), .mem_dst(mem_dst),
    .halt_req(halt_req), .step_req(step_req), .clr_cnt(clr_cnt),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .id_ex_flush(id_ex_flush),
    .if_id_flush(if_id_flush), .fw1(fw1), .fw2(fw2), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_is_branch = 0; id_is_jump = 0; br_taken = 0;
    ex_memread = 0; ex_regwrite = 0; ex_dst = 0;
    mem_memread = 0; mem_regwrite = 0; mem_dst = 0;
    halt_req = 0; step_req = 0; clr_cnt = 0;
  endtask

  task automatic load_use(input logic [4:0] r);
    ex_memread = 1; ex_regwrite = 1; ex_dst = r; id_rs = r; id_uses_rs = 1;
  endtask

  task automatic stall_state(input string tag, input logic exp);
    chk({tag, "_pc_hold"}, pc_hold, exp);
    chk({tag, "_if_id_hold"}, if_id_hold, exp);
    chk({tag, "_id_ex_flush"}, id_ex_flush, exp);
  endtask

  initial begin
    idle();
    reset = 0;
    mem_regwrite = 1; mem_dst = 3; id_rs = 3;
    #2;
    stall_state("rst", 1);
    chk("rst_if_id_flush", if_id_flush, 0);
    chk("rst_fw1", fw1, 0);
    chk("rst_halted", halted, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    idle();
    @(posedge clock); #1;
    reset = 1; #1;
    chk("post_rst_hold", pc_hold, 1);
    tick();
    stall_state("live", 0);
    chk("live_stall_cnt", stall_cnt, 0);

    // load-use: one stall cycle
    load_use(5); #1;
    stall_state("lu", 1);
    chk("lu_if_id_flush", if_id_flush, 0);
    tick();
    ex_memread = 0; ex_regwrite = 0; ex_dst = 0; #1;
    stall_state("lu_after", 0);
    chk("lu_stall_cnt", stall_cnt, 1);

    // branch after load: two stalls, then forward from EX/MEM and squash
    idle(); clr_cnt = 1; tick(); clr_cnt = 0; #1;
    chk("clr_stall_cnt", stall_cnt, 0);
    id_is_branch = 1; br_taken = 1; id_rs = 8; id_uses_rs = 1;
    ex_memread = 1; ex_regwrite = 1; ex_dst = 8; #1;
    stall_state("bl1", 1);
    chk("bl1_squash", if_id_flush, 0);
    tick();
    ex_memread = 0; ex_regwrite = 0; ex_dst = 0; mem_memread = 1; mem_regwrite = 1; mem_dst = 8; #1;
    stall_state("bl2", 1);
    chk("bl2_squash", if_id_flush, 0);
    chk("bl2_stall_cnt", stall_cnt, 1);
    tick();
    mem_memread = 0; #1;
    stall_state("bl3", 0);
    chk("bl3_fw1", fw1, 1);
    chk("bl3_fw2", fw2, 0);
    chk("bl3_squash", if_id_flush, 1);
    chk("bl3_stall_cnt", stall_cnt, 2);
    tick();
    idle(); #1;
    chk("br_flush_cnt", flush_cnt, 1);

    // branch on an EX ALU result: single stall
    id_is_branch = 1; id_rt = 9; id_uses_rt = 1; ex_regwrite = 1; ex_dst = 9; #1;
    stall_state("bex", 1);
    tick();
    ex_regwrite = 0; ex_dst = 0; #1;
    stall_state("bex_after", 0);
    chk("bex_stall_cnt", stall_cnt, 3);

    // branch on a load in MEM: single stall, no forward of load data
    idle(); id_is_branch = 1; id_rs = 4; id_uses_rs = 1;
    mem_memread = 1; mem_regwrite = 1; mem_dst = 4; #1;
    stall_state("bmem", 1);
    chk("bmem_fw1", fw1, 0);
    tick();
    mem_memread = 0; mem_regwrite = 0; mem_dst = 0; #1;
    stall_state("bmem_after", 0);
    chk("bmem_stall_cnt", stall_cnt, 4);

    // non-branch on ALU result in EX, and unused operand: no stall
    idle(); id_rs = 6; id_uses_rs = 1; ex_regwrite = 1; ex_dst = 6; #1;
    chk("nb_alu_hold", pc_hold, 0);
    idle(); id_rt = 7; ex_memread = 1; ex_dst = 7; #1;
    chk("unused_rt_hold", pc_hold, 0);

    // jump squashes; not-taken branch does not
    idle(); id_is_jump = 1; #1;
    chk("j_squash", if_id_flush, 1);
    tick();
    idle(); id_is_branch = 1; br_taken = 0; #1;
    chk("j_flush_cnt", flush_cnt, 2);
    chk("bnt_squash", if_id_flush, 0);
    tick();
    chk("bnt_flush_cnt", flush_cnt, 2);

    // register zero never hazards or forwards
    idle(); ex_memread = 1; ex_dst = 0; id_rs = 0; id_uses_rs = 1;
    mem_regwrite = 1; mem_dst = 0; #1;
    chk("r0_hold", pc_hold, 0);
    chk("r0_fw1", fw1, 0);
    idle(); mem_regwrite = 1; mem_dst = 12; id_rt = 12; #1;
    chk("fw2_on", fw2, 1);
    chk("fw2_fw1_off", fw1, 0);

    // halt, single step, release
    idle(); halt_req = 1; #1;
    chk("h0_halted", halted, 0);
    chk("h0_hold", pc_hold, 0);
    tick();
    chk("h1_halted", halted, 1);
    stall_state("h1", 1);
    chk("h1_squash", if_id_flush, 0);
    tick();
    chk("h2_stall_cnt", stall_cnt, 4);
    step_req = 1; tick(); step_req = 0; #1;
    chk("step_halted", halted, 0);
    chk("step_hold", pc_hold, 0);
    tick();
    chk("step_back_halted", halted, 1);
    step_req = 1; tick(); step_req = 0;
    load_use(5); #1;
    chk("step_lu_halted", halted, 0);
    chk("step_lu_hold", pc_hold, 1);
    tick();
    idle(); halt_req = 1; #1;
    chk("step_lu_back", halted, 1);
    chk("step_lu_cnt", stall_cnt, 5);
    halt_req = 0; #1;
    chk("rel_still_halted", halted, 1);
    tick();
    chk("rel_run", halted, 0);
    chk("rel_hold", pc_hold, 0);

    // step wins over release; STEP returns to HALT without halt_req
    halt_req = 1; tick();
    chk("prio_halted", halted, 1);
    halt_req = 0; step_req = 1; tick(); step_req = 0; #1;
    chk("prio_step", halted, 0);
    tick();
    chk("prio_back_halt", halted, 1);
    tick();
    chk("prio_run", halted, 0);

    // halt_req is ignored in STALL2 and re-sampled in RUN
    halt_req = 1; id_is_branch = 1; id_rs = 8; id_uses_rs = 1; ex_memread = 1; ex_dst = 8;
    tick();
    ex_memread = 0; ex_dst = 0; #1;
    chk("s2h_halted", halted, 0);
    chk("s2h_hold", pc_hold, 1);
    tick();
    chk("s2h_run_halted", halted, 0);
    chk("s2h_run_hold", pc_hold, 0);
    tick();
    chk("s2h_halt", halted, 1);
    halt_req = 0; tick();

    // reset in the middle of STALL2
    idle(); id_is_branch = 1; id_rs = 8; id_uses_rs = 1; ex_memread = 1; ex_dst = 8;
    tick();
    idle(); #1;
    chk("pre_rst_stall2", pc_hold, 1);
    reset = 0; #1;
    chk("mid_rst_stall_cnt", stall_cnt, 0);
    chk("mid_rst_flush_cnt", flush_cnt, 0);
    chk("mid_rst_halted", halted, 0);
    @(posedge clock); #1;
    reset = 1;
    tick();
    chk("after_rst_hold", pc_hold, 0);

    // clear wins over a simultaneous stall
    load_use(5); tick();
    chk("pre_clr_cnt", stall_cnt, 1);
    clr_cnt = 1; tick(); clr_cnt = 0; #1;
    chk("clr_with_stall", stall_cnt, 0);

    // saturation
    repeat (65535) tick();
    chk("sat_reach", stall_cnt, 16'hFFFF);
    repeat (3) tick();
    chk("sat_hold", stall_cnt, 16'hFFFF);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
